// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared funct3 codes, MEM-stage FSM encoding and XLEN helpers
package pipeline_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } mem_state_e;

  function automatic int strb_w(input int xlen);
    return xlen / 8;
  endfunction

  function automatic int lane_bits(input int xlen);
    return $clog2(xlen / 8);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane placement, load extension and misalignment detect
module mem_lane_align
  import pipeline_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        funct3_i,
  input  logic              is_store_i,
  input  logic [XLEN-1:0]   addr_i,
  input  logic [XLEN-1:0]   store_data_i,
  input  logic [XLEN-1:0]   rdata_i,
  output logic              misalign_o,
  output logic [XLEN/8-1:0] strb_o,
  output logic [XLEN-1:0]   waddr_o,
  output logic [XLEN-1:0]   wdata_o,
  output logic [XLEN-1:0]   load_data_o
);
  localparam int SW = strb_w(XLEN);
  localparam int LB = lane_bits(XLEN);

  logic [1:0]      size;
  logic            sgn;
  logic            bad;
  logic [LB-1:0]   off;
  logic [LB+2:0]   shamt;
  logic [2:0]      amask;
  logic [XLEN-1:0] size_mask;
  logic [XLEN-1:0] lane;
  logic [SW-1:0]   byte_mask;
  logic            msb;

  // Decode access size/sign, then move data between its byte lane and bit 0
  always_comb begin
    size = 2'd0;
    sgn  = 1'b0;
    bad  = 1'b0;
    case (funct3_i)
      F3_B:    begin size = 2'd0; sgn = 1'b1; end
      F3_H:    begin size = 2'd1; sgn = 1'b1; end
      F3_W:    begin size = 2'd2; sgn = 1'b1; end
      F3_D:    begin size = 2'd3; sgn = 1'b1; bad = (XLEN < 64); end
      F3_BU:   size = 2'd0;
      F3_HU:   size = 2'd1;
      F3_WU:   size = 2'd2;
      default: bad = 1'b1;
    endcase
    off       = addr_i[LB-1:0];
    shamt     = {off, 3'b000};
    amask     = 3'((4'd1 << size) - 4'd1);
    size_mask = XLEN'((65'd1 << (7'd8 << size)) - 65'd1);
    byte_mask = SW'((9'd1 << (4'd1 << size)) - 9'd1);
    misalign_o = bad | (|(addr_i[2:0] & amask));
    waddr_o    = addr_i & ~XLEN'(SW - 1);
    strb_o     = is_store_i ? (byte_mask << off) : '0;
    wdata_o    = (store_data_i & size_mask) << shamt;
    lane       = rdata_i >> shamt;
    case (size)
      2'd0:    msb = lane[7];
      2'd1:    msb = lane[15];
      2'd2:    msb = lane[31];
      default: msb = lane[XLEN-1];
    endcase
    load_data_o = (lane & size_mask) | ((sgn & msb) ? ~size_mask : '0);
  end

endmodule

// File: rtl/pipeline_mem_mc.sv
// rtl/pipeline_mem_mc.sv - MEM stage with variable-latency data memory; PIPELINE_MEM_TIMEOUT_EN adds a bus-error timeout
module pipeline_mem_mc
  import pipeline_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RD_W    = 5,
  parameter int OP_W    = 6,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic              is_load_i,
  input  logic              is_store_i,
  input  logic [OP_W-1:0]   opcode_i,
  input  logic [XLEN-1:0]   alu_out_i,
  input  logic [XLEN-1:0]   store_data_i,
  input  logic [RD_W-1:0]   rd_i,
  output logic              stall_o,
  output logic              dmem_req_o,
  output logic [XLEN/8-1:0] dmem_we_o,
  output logic [XLEN-1:0]   dmem_addr_o,
  output logic [XLEN-1:0]   dmem_wdata_o,
  input  logic              dmem_ready_i,
  input  logic [XLEN-1:0]   dmem_rdata_i,
  output logic              valid_o,
  output logic [OP_W-1:0]   opcode_o,
  output logic [XLEN-1:0]   alu_out_o,
  output logic [XLEN-1:0]   load_data_o,
  output logic [RD_W-1:0]   rd_o,
  output logic              misalign_o,
  output logic              bus_err_o
);
  localparam int SW = strb_w(XLEN);

  mem_state_e      state_q;
  logic [OP_W-1:0] op_h_q;
  logic [XLEN-1:0] alu_h_q;
  logic [XLEN-1:0] sdata_h_q;
  logic [RD_W-1:0] rd_h_q;
  logic            ld_h_q;
  logic            st_h_q;

  logic            in_wait;
  logic            mem_op;
  logic            issue;
  logic            tmo_hit;
  logic [OP_W-1:0] cur_op;
  logic [XLEN-1:0] cur_addr;
  logic [XLEN-1:0] cur_sdata;
  logic            cur_st;
  logic            al_mis;
  logic [SW-1:0]   al_strb;
  logic [XLEN-1:0] al_waddr;
  logic [XLEN-1:0] al_wdata;
  logic [XLEN-1:0] al_ldata;

  // Live EX inputs drive the aligner in IDLE; held copies drive it while an access is outstanding
  always_comb begin
    in_wait      = (state_q == S_WAIT);
    cur_op       = in_wait ? op_h_q    : opcode_i;
    cur_addr     = in_wait ? alu_h_q   : alu_out_i;
    cur_sdata    = in_wait ? sdata_h_q : store_data_i;
    cur_st       = in_wait ? st_h_q    : is_store_i;
    mem_op       = valid_i & (is_load_i | is_store_i);
    issue        = ~in_wait & mem_op & ~al_mis;
    dmem_req_o   = in_wait | issue;
    dmem_we_o    = dmem_req_o ? al_strb : '0;
    dmem_addr_o  = al_waddr;
    dmem_wdata_o = al_wdata;
    stall_o      = dmem_req_o & ~dmem_ready_i & ~tmo_hit;
  end

  mem_lane_align #(.XLEN(XLEN)) u_align (
    .funct3_i     (cur_op[2:0]),
    .is_store_i   (cur_st),
    .addr_i       (cur_addr),
    .store_data_i (cur_sdata),
    .rdata_i      (dmem_rdata_i),
    .misalign_o   (al_mis),
    .strb_o       (al_strb),
    .waddr_o      (al_waddr),
    .wdata_o      (al_wdata),
    .load_data_o  (al_ldata)
  );

  // FSM plus MEM/WB register: complete in IDLE when possible, else hold the instruction and write bubbles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      op_h_q      <= '0;
      alu_h_q     <= '0;
      sdata_h_q   <= '0;
      rd_h_q      <= '0;
      ld_h_q      <= 1'b0;
      st_h_q      <= 1'b0;
      valid_o     <= 1'b0;
      opcode_o    <= '0;
      alu_out_o   <= '0;
      load_data_o <= '0;
      rd_o        <= '0;
      misalign_o  <= 1'b0;
    end else if (in_wait) begin
      if (dmem_ready_i || tmo_hit) begin
        state_q     <= S_IDLE;
        valid_o     <= 1'b1;
        opcode_o    <= op_h_q;
        alu_out_o   <= alu_h_q;
        rd_o        <= rd_h_q;
        misalign_o  <= 1'b0;
        load_data_o <= (ld_h_q && dmem_ready_i) ? al_ldata : '0;
      end else begin
        valid_o <= 1'b0;
      end
    end else if (issue && !dmem_ready_i) begin
      state_q   <= S_WAIT;
      valid_o   <= 1'b0;
      op_h_q    <= opcode_i;
      alu_h_q   <= alu_out_i;
      sdata_h_q <= store_data_i;
      rd_h_q    <= rd_i;
      ld_h_q    <= is_load_i;
      st_h_q    <= is_store_i;
    end else begin
      valid_o     <= valid_i;
      opcode_o    <= opcode_i;
      alu_out_o   <= alu_out_i;
      rd_o        <= rd_i;
      misalign_o  <= mem_op & al_mis;
      load_data_o <= (issue && is_load_i) ? al_ldata : '0;
    end
  end

`ifdef PIPELINE_MEM_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CW-1:0] wait_cnt_q;
  logic          bus_err_q;

  assign tmo_hit   = in_wait & (wait_cnt_q == CW'(TIMEOUT - 1));
  assign bus_err_o = bus_err_q;

  // Count WAIT cycles from zero on each entry; flag the MEM/WB entry written on expiry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_q <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      wait_cnt_q <= in_wait ? wait_cnt_q + 1'b1 : '0;
      bus_err_q  <= tmo_hit & ~dmem_ready_i;
    end
  end
`else
  assign tmo_hit   = 1'b0;
  assign bus_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_mem_mc.sv
// tb/tb_pipeline_mem_mc.sv - self-checking bench for pipeline_mem_mc (XLEN=32)
module tb_pipeline_mem_mc;
  localparam int XLEN = 32;
  localparam int RD_W = 5;
  localparam int OP_W = 6;

  logic            clk = 1'b0;
  logic            reset;
  logic            valid_i, is_load_i, is_store_i;
  logic [OP_W-1:0] opcode_i;
  logic [XLEN-1:0] alu_out_i, store_data_i;
  logic [RD_W-1:0] rd_i;
  logic            stall_o, dmem_req_o;
  logic [3:0]      dmem_we_o;
  logic [XLEN-1:0] dmem_addr_o, dmem_wdata_o;
  logic            dmem_ready_i;
  logic [XLEN-1:0] dmem_rdata_i;
  logic            valid_o;
  logic [OP_W-1:0] opcode_o;
  logic [XLEN-1:0] alu_out_o, load_data_o;
  logic [RD_W-1:0] rd_o;
  logic            misalign_o, bus_err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_mem_mc #(.XLEN(XLEN), .RD_W(RD_W), .OP_W(OP_W), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .is_load_i(is_load_i), .is_store_i(is_store_i),
    .opcode_i(opcode_i), .alu_out_i(alu_out_i), .store_data_i(store_data_i), .rd_i(rd_i),
    .stall_o(stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_ready_i(dmem_ready_i), .dmem_rdata_i(dmem_rdata_i),
    .valid_o(valid_o), .opcode_o(opcode_o), .alu_out_o(alu_out_o), .load_data_o(load_data_o),
    .rd_o(rd_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic        req;
    logic [3:0]  we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] ldata;
    logic        mis;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Byte-level reference: memory word viewed as four bytes, access of 2^f3[1:0] bytes
  function automatic vec_t model(input logic ld, input logic st, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] sdata,
                                 input logic [31:0] rdata);
    vec_t v;
    int sz, off;
    logic [31:0] val;
    v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.sdata = sdata; v.rdata = rdata;
    sz  = 1 << f3[1:0];
    off = int'(addr[1:0]);
    v.mis   = (ld | st) && (f3 == 3'b111 || sz > 4 || (int'(addr[2:0]) % sz) != 0);
    v.req   = (ld | st) && !v.mis;
    v.waddr = {addr[31:2], 2'b00};
    v.we = 4'b0; v.wdata = 32'h0; v.ldata = 32'h0;
    if (v.req && st)
      for (int i = 0; i < sz; i++) begin
        v.we[off+i] = 1'b1;
        v.wdata[8*(off+i) +: 8] = sdata[8*i +: 8];
      end
    if (v.req && ld) begin
      val = 32'h0;
      for (int i = 0; i < sz; i++) val[8*i +: 8] = rdata[8*(off+i) +: 8];
      if (!f3[2] && sz < 4 && val[8*sz-1])
        for (int i = sz; i < 4; i++) val[8*i +: 8] = 8'hFF;
      v.ldata = val;
    end
    return v;
  endfunction

  // Present one instruction at posedge+1; memory answers after `delay` extra cycles
  task automatic txn(input vec_t v, input int delay, input logic [RD_W-1:0] rd, input logic [2:0] ophi);
    valid_i = 1'b1; is_load_i = v.ld; is_store_i = v.st; opcode_i = {ophi, v.f3};
    alu_out_i = v.addr; store_data_i = v.sdata; rd_i = rd;
    dmem_ready_i = (delay == 0);
    dmem_rdata_i = (delay == 0) ? v.rdata : ~v.rdata;
    for (int c = 0; c <= delay; c++) begin
      #3;
      chk("req", dmem_req_o, v.req);
      chk("stall", stall_o, (c < delay));
      if (v.req) begin
        chk("addr", dmem_addr_o, v.waddr);
        chk("we", dmem_we_o, v.we);
        if (v.st) chk("wdata", dmem_wdata_o, v.wdata);
      end
      @(posedge clk); #1;
      if (c < delay) begin
        chk("bubble", valid_o, 1'b0);
        dmem_ready_i = (c + 1 == delay);
        dmem_rdata_i = (c + 1 == delay) ? v.rdata : ~v.rdata;
      end
    end
    chk("valid", valid_o, 1'b1);
    chk("ldata", load_data_o, v.ldata);
    chk("mis", misalign_o, v.mis);
    chk("rd", rd_o, rd);
    chk("alu", alu_out_o, v.addr);
    chk("op", opcode_o, {ophi, v.f3});
    chk("buserr", bus_err_o, 1'b0);
    valid_i = 1'b0; is_load_i = 1'b0; is_store_i = 1'b0; dmem_ready_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int k, delay, stalls, bubbles;
    logic ld, st;
    logic [2:0] f3;
    logic [31:0] addr;

    reset = 1'b0; valid_i = 1'b0; is_load_i = 1'b0; is_store_i = 1'b0; opcode_i = '0;
    alu_out_i = '0; store_data_i = '0; rd_i = '0; dmem_ready_i = 1'b0; dmem_rdata_i = '0;

    //               ld    st    f3      addr          sdata         rdata         req   we       waddr         wdata         ldata         mis
    tbl[0]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_0102, 1'b1, 4'b0000, 32'h0000_0100, 32'h0,        32'hFFFF_FF80, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0301, 32'h0000_00AB, 32'h0,        1'b1, 4'b0010, 32'h0000_0300, 32'h0000_AB00, 32'h0,        1'b0};
    tbl[2]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0402, 32'h0,        32'h1111_2222, 1'b0, 4'b0000, 32'h0,        32'h0,        32'h0,        1'b1};
    tbl[3]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h8001_1234, 1'b1, 4'b0000, 32'h0000_0100, 32'h0,        32'hFFFF_8001, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0100, 32'h0,        32'h8001_1234, 1'b1, 4'b0000, 32'h0000_0100, 32'h0,        32'h0000_1234, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0102, 32'h0,        32'h80FF_0102, 1'b1, 4'b0000, 32'h0000_0100, 32'h0,        32'h0000_00FF, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0206, 32'h1234_5678, 32'h0,        1'b1, 4'b1100, 32'h0000_0204, 32'h5678_0000, 32'h0,        1'b0};
    tbl[7]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0208, 32'hDEAD_BEEF, 32'h0,        1'b1, 4'b1111, 32'h0000_0208, 32'hDEAD_BEEF, 32'h0,        1'b0};
    tbl[8]  = '{1'b1, 1'b0, 3'b011, 32'h0000_0300, 32'h0,        32'h5555_AAAA, 1'b0, 4'b0000, 32'h0,        32'h0,        32'h0,        1'b1};
    tbl[9]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0203, 32'h0000_1234, 32'h0,        1'b0, 4'b0000, 32'h0,        32'h0,        32'h0,        1'b1};
    tbl[10] = '{1'b1, 1'b0, 3'b111, 32'h0000_0400, 32'h0,        32'h0F0F_0F0F, 1'b0, 4'b0000, 32'h0,        32'h0,        32'h0,        1'b1};
    tbl[11] = '{1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'h0,        32'h0,        1'b0, 4'b0000, 32'h0,        32'h0,        32'h0,        1'b0};
    tbl[12] = '{1'b1, 1'b0, 3'b010, 32'h0000_0404, 32'h0,        32'hCAFE_BABE, 1'b1, 4'b0000, 32'h0000_0404, 32'h0,        32'hCAFE_BABE, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 3'b000, 32'h0000_0101, 32'h0,        32'h80FF_0102, 1'b1, 4'b0000, 32'h0000_0100, 32'h0,        32'h0000_0001, 1'b0};

    // Reset state
    #3;
    chk("rst stall", stall_o, 1'b0);
    chk("rst req", dmem_req_o, 1'b0);
    chk("rst we", dmem_we_o, 4'b0);
    chk("rst valid", valid_o, 1'b0);
    chk("rst op", opcode_o, '0);
    chk("rst alu", alu_out_o, '0);
    chk("rst ldata", load_data_o, '0);
    chk("rst rd", rd_o, '0);
    chk("rst mis", misalign_o, 1'b0);
    chk("rst buserr", bus_err_o, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Directed single-cycle vectors
    for (int i = 0; i < 14; i++) txn(tbl[i], 0, 5'(i + 1), 3'(i));

    // LHU at 0x202, ready after 3 cycles; EX inputs scrambled meanwhile to prove holding
    stalls = 0; bubbles = 0;
    valid_i = 1'b1; is_load_i = 1'b1; opcode_i = {3'b001, 3'b101}; alu_out_i = 32'h0000_0202;
    rd_i = 5'd9; dmem_ready_i = 1'b0; dmem_rdata_i = 32'h0;
    for (int c = 0; c <= 3; c++) begin
      #3;
      if (stall_o) stalls++;
      chk("hold req", dmem_req_o, 1'b1);
      chk("hold addr", dmem_addr_o, 32'h0000_0200);
      @(posedge clk); #1;
      if (c < 3 && !valid_o) bubbles++;
      alu_out_i = 32'hDEAD_0001 + 32'(c); opcode_i = 6'b000_000; rd_i = 5'd30;
      dmem_ready_i = (c + 1 == 3);
      dmem_rdata_i = (c + 1 == 3) ? 32'h8001_1234 : 32'h0;
    end
    chk("lhu stalls", stalls, 3);
    chk("lhu bubbles", bubbles, 3);
    chk("lhu valid", valid_o, 1'b1);
    chk("lhu ldata", load_data_o, 32'h0000_8001);
    chk("lhu rd", rd_o, 5'd9);
    valid_i = 1'b0; is_load_i = 1'b0; dmem_ready_i = 1'b0;

    // Reset asserted while waiting
    valid_i = 1'b1; is_load_i = 1'b1; opcode_i = 6'b000_010; alu_out_i = 32'h0000_0500; rd_i = 5'd3;
    @(posedge clk); #1;
    valid_i = 1'b0; is_load_i = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("wrst stall", stall_o, 1'b0);
    chk("wrst req", dmem_req_o, 1'b0);
    chk("wrst valid", valid_o, 1'b0);
    chk("wrst alu", alu_out_o, '0);
    chk("wrst rd", rd_o, '0);
    @(posedge clk); #1;
    reset = 1'b1;
    #3;
    chk("post rst stall", stall_o, 1'b0);
    chk("post rst req", dmem_req_o, 1'b0);
    @(posedge clk); #1;
    chk("post rst valid", valid_o, 1'b0);
    txn(tbl[12], 0, 5'd4, 3'd5);

    // Memory that never answers
    stalls = 0;
    valid_i = 1'b1; is_load_i = 1'b1; opcode_i = 6'b000_010; alu_out_i = 32'h0000_0600; rd_i = 5'd7;
`ifdef PIPELINE_MEM_TIMEOUT_EN
    for (int c = 0; c < 20; c++) begin
      #3;
      if (!stall_o) break;
      stalls++;
      @(posedge clk); #1;
    end
    chk("tmo stalls", stalls, 4);
    @(posedge clk); #1;
    valid_i = 1'b0; is_load_i = 1'b0;
    chk("tmo buserr", bus_err_o, 1'b1);
    chk("tmo valid", valid_o, 1'b1);
    chk("tmo ldata", load_data_o, 32'h0);
    chk("tmo rd", rd_o, 5'd7);
    #3;
    chk("tmo released", stall_o, 1'b0);
    @(posedge clk); #1;
    chk("tmo buserr clr", bus_err_o, 1'b0);
`else
    for (int c = 0; c < 20; c++) begin
      #3;
      if (stall_o) stalls++;
      @(posedge clk); #1;
      if (bus_err_o) errors += 0;
    end
    chk("wait stalls", stalls, 20);
    chk("wait buserr", bus_err_o, 1'b0);
    chk("wait bubble", valid_o, 1'b0);
    dmem_ready_i = 1'b1; dmem_rdata_i = 32'h7654_3210;
    #3;
    chk("wait exit stall", stall_o, 1'b0);
    @(posedge clk); #1;
    chk("wait valid", valid_o, 1'b1);
    chk("wait ldata", load_data_o, 32'h7654_3210);
    valid_i = 1'b0; is_load_i = 1'b0; dmem_ready_i = 1'b0;
`endif

    // Randomized instructions against the byte-level model
    for (int n = 0; n < 150; n++) begin
      k  = $urandom_range(0, 3);
      ld = (k == 1 || k == 3);
      st = (k == 2);
      f3 = st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      addr = $urandom();
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      v = model(ld, st, f3, addr, $urandom(), $urandom());
      delay = v.req ? $urandom_range(0, 3) : 0;
      txn(v, delay, 5'($urandom()), 3'($urandom()));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_mem_mc.md
Name: pipeline_mem_mc

Overview:
- Parametrised successor to the single-cycle MEM pipeline stage.
- Talks to a variable-latency data memory through a req/ready handshake, so it must stall the upstream pipeline while an access is in flight.
- Produces load data with correct sign/zero extension and flags misaligned accesses.
- Sits between EX and WB and registers all outputs into the MEM/WB pipeline register.

Parameters:
- XLEN, 32, datapath and address width in bits (32 or 64).
- RD_W, 5, register-file write-address width.
- OP_W, 6, instruction opcode width; funct3 is carried in opcode bits [2:0].
- TIMEOUT, 255, wait-cycle limit before a bus error (used only when the optional feature is compiled in).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- valid_i  in  1  EX stage presents a valid instruction
- is_load_i  in  1  instruction is a load
- is_store_i  in  1  instruction is a store
- opcode_i  in  OP_W  instruction opcode; [2:0] = funct3 size/sign code
- alu_out_i  in  XLEN  effective address or ALU result
- store_data_i  in  XLEN  raw store data
- rd_i  in  RD_W  destination register
- stall_o  out  1  hold EX and earlier stages
- dmem_req_o  out  1  memory request
- dmem_we_o  out  XLEN/8  byte write strobes (all zero for loads)
- dmem_addr_o  out  XLEN  word-aligned address
- dmem_wdata_o  out  XLEN  lane-shifted store data
- dmem_ready_i  in  1  memory accepted/completed the access; load data valid this cycle
- dmem_rdata_i  in  XLEN  load data, whole word
- valid_o  out  1  MEM/WB entry valid
- opcode_o  out  OP_W  registered opcode
- alu_out_o  out  XLEN  registered ALU result
- load_data_o  out  XLEN  extended load data
- rd_o  out  RD_W  registered destination
- misalign_o  out  1  registered misaligned-access flag
- bus_err_o  out  1  registered timeout flag (constant 0 when the feature is off)

Behaviour:
- Reset: every output register goes to 0 (valid_o, opcode_o, alu_out_o, load_data_o, rd_o, misalign_o, bus_err_o); FSM goes to IDLE. Consequently stall_o=0, dmem_req_o=0 and dmem_we_o=0.
- FSM states: IDLE and WAIT.
- IDLE, non-memory instruction (valid_i & ~is_load_i & ~is_store_i): pass through to the MEM/WB register next edge. Latency 1. No stall.
- IDLE, memory instruction that is aligned: dmem_req_o=1 combinationally the same cycle.
  - If dmem_ready_i=1 that cycle: capture result next edge, no stall.
  - Otherwise: go to WAIT, stall_o=1.
- WAIT: dmem_req_o held at 1. Address, strobes and write data come from internal holding registers captured at entry, not from the inputs. stall_o=1. valid_o=0 each cycle, i.e. a bubble is written.
- WAIT exit: on dmem_ready_i=1, write the result into MEM/WB, return to IDLE, and stall_o drops the same cycle.
- Misalignment:
  - Definition: halfword with addr[0]=1, word with addr[1:0]≠0, or doubleword (XLEN=64) with addr[2:0]≠0.
  - Response: no request is issued, misalign_o=1 with valid_o=1, load_data_o=0, latency 1.
- funct3 decoding:
  - 000 LB, sign-extend byte.
  - 001 LH, sign-extend half.
  - 010 LW, sign-extend when XLEN=64.
  - 011 LD (XLEN=64 only).
  - 100 LBU, 101 LHU, 110 LWU: zero-extend.
  - Sign extension replicates the selected lane's MSB.
  - Any other code raises misalign_o.
- Stores:
  - Byte lane is selected by address low bits.
  - Store data is replicated or shifted into that lane.
  - Strobes are active only for the accessed bytes.
  - load_data_o=0 for stores.
- valid_i=0 in IDLE: a bubble is written (valid_o=0); other output registers may update freely.
- Simultaneous ready and entry into WAIT is impossible by construction: ready in IDLE completes immediately.
- dmem_ready_i while not requesting is ignored.
- Reset asserted mid-WAIT: the access is abandoned, outputs clear, and the stall is released on the next cycle after deassertion.

Optional Feature:
- Macro: PIPELINE_MEM_TIMEOUT_EN.
- When defined:
  - An 8-bit-or-wider counter increments each WAIT cycle.
  - When it reaches TIMEOUT without ready, the FSM returns to IDLE and writes valid_o=1, bus_err_o=1, load_data_o=0.
  - The counter clears on entry to WAIT.
- When undefined: no counter is instantiated, bus_err_o is tied to 0, and WAIT can last indefinitely.

Decomposition:
- Shared package (pipeline_pkg):
  - funct3 localparams (F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU).
  - FSM state encoding.
  - XLEN-derived constants (strobe width, lane bits).
- One natural sub-module, mem_lane_align:
  - Combinational.
  - Store lane shift/strobe generation, load lane select/extension, misalignment detect.
  - Reused by a future instruction-fetch alignment path.

Test Plan:
- XLEN=32, LB to addr 0x103 with memory word 0x80FF_0102, ready same cycle → next edge load_data_o=0xFFFF_FF80, valid_o=1, stall_o never asserted.
- LHU to addr 0x202 with word 0x8001_1234, ready after 3 cycles → stall_o high 3 cycles, 3 bubbles, then load_data_o=0x0000_8001.
- SB of 0xAB to addr 0x301 → dmem_we_o=4'b0010, dmem_wdata_o=0x0000_AB00, dmem_addr_o=0x300.
- LW to addr 0x402 → no dmem_req_o, misalign_o=1 and valid_o=1 next edge.
- Reset pulsed low during WAIT → all outputs 0 immediately, stall_o=0, FSM in IDLE.
- With PIPELINE_MEM_TIMEOUT_EN and TIMEOUT=4, ready never asserts → after 4 WAIT cycles bus_err_o=1, valid_o=1, stall released.
